// File: rtl/coproc_mem_pkg.sv
// Shared constants and types for the coprocessor shared-memory arbiter.
package coproc_mem_pkg;

  localparam int DATA_W      = 32;
  localparam int CONFIG_ADDR = 0;
  localparam int STATUS_ADDR = 1;

  typedef enum logic {
    s_Idle    = 1'b0,
    s_Granted = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first requester after the last owner, wrapping.
module rr_priority_picker #(
  parameter int N = 2,
  parameter int W = 1
) (
  input  logic [N-1:0] i_req,
  input  logic [W-1:0] i_last,
  output logic [N-1:0] o_winner,
  output logic         o_valid
);

  int          cand_int;
  logic [W-1:0] cand;

  always_comb begin
    o_winner = '0;
    o_valid  = 1'b0;
    cand_int = 0;
    cand     = '0;
    for (int off = 1; off <= N; off++) begin
      cand_int = int'(i_last) + off;
      if (cand_int >= N) cand_int = cand_int - N;
      cand = W'(cand_int);
      if (!o_valid && i_req[cand]) begin
        o_winner[cand] = 1'b1;
        o_valid        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/shared_memory_arbiter.sv
// Shared word memory with round-robin bus grant, combinational reads,
// clocked writes and a registered status flag from mem[1][0].
module shared_memory_arbiter
  import coproc_mem_pkg::*;
#(
  parameter int n_requesters    = 2,
  parameter int memory_size     = 1024,
  parameter int memory_size_log = 10
) (
  input  logic                       i_Clock,
  input  logic                       i_Reset,
  input  logic [n_requesters-1:0]    i_Grant_Request,
  output logic [n_requesters-1:0]    o_Grant,
  input  logic [memory_size_log-1:0] i_Memory_Address,
  input  logic                       i_Write_Enable,
  inout  wire  [DATA_W-1:0]          io_Memory_Data,
  output logic                       o_Data_Ready
);

  localparam int OWNER_W = (n_requesters > 1) ? $clog2(n_requesters) : 1;
  localparam logic [memory_size_log:0] MEM_SIZE = memory_size[memory_size_log:0];

  arb_state_e                state_q, state_d;
  logic [n_requesters-1:0]   grant_q, grant_d;
  logic [OWNER_W-1:0]        owner_q, owner_d;
  logic                      data_ready_q, data_ready_d;

  logic [n_requesters-1:0]   pick_onehot;
  logic                      pick_valid;
  logic [OWNER_W-1:0]        pick_idx;

  logic [DATA_W-1:0]         mem [memory_size];
  logic                      we_hi;
  logic                      addr_ok;
  logic                      rd_en;
  logic                      wr_en;
  logic [DATA_W-1:0]         rd_data;

  rr_priority_picker #(
    .N (n_requesters),
    .W (OWNER_W)
  ) u_picker (
    .i_req    (i_Grant_Request),
    .i_last   (owner_q),
    .o_winner (pick_onehot),
    .o_valid  (pick_valid)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < n_requesters; i++) begin
      if (pick_onehot[i]) pick_idx = OWNER_W'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    owner_d = owner_q;
    case (state_q)
      s_Idle: begin
        grant_d = '0;
        if (pick_valid) begin
          grant_d = pick_onehot;
          owner_d = pick_idx;
          state_d = s_Granted;
        end
      end
      s_Granted: begin
        // No preemption: only the owner's own request decides release.
        if (!i_Grant_Request[owner_q]) begin
          grant_d = '0;
          state_d = s_Idle;
        end
      end
      default: begin
        grant_d = '0;
        state_d = s_Idle;
      end
    endcase
  end

  always_ff @(posedge i_Clock or negedge i_Reset) begin
    if (!i_Reset) begin
      state_q      <= s_Idle;
      grant_q      <= '0;
      owner_q      <= OWNER_W'(n_requesters - 1);
      data_ready_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      owner_q      <= owner_d;
      data_ready_q <= data_ready_d;
    end
  end

  // A floating enable line must never count as a write, so only a solid 1 does.
  assign we_hi   = (i_Write_Enable === 1'b1);
  assign addr_ok = !$isunknown(i_Memory_Address) &&
                   ({1'b0, i_Memory_Address} < MEM_SIZE);
  assign rd_en   = (|grant_q) && !we_hi;
  assign wr_en   = (|grant_q) && we_hi && addr_ok;
  assign rd_data = addr_ok ? mem[i_Memory_Address] : '0;

  assign io_Memory_Data = rd_en ? rd_data : {DATA_W{1'bz}};

  // Array has no reset so contents survive a controller reset.
  always_ff @(posedge i_Clock) begin
    if (wr_en) mem[i_Memory_Address] <= io_Memory_Data;
  end

  assign data_ready_d = mem[STATUS_ADDR][0];

  assign o_Grant      = grant_q;
  assign o_Data_Ready = data_ready_q;

endmodule

// File: tb/tb_shared_memory_arbiter.sv
// Directed bench for shared_memory_arbiter with a 1000-word memory.
module tb_shared_memory_arbiter;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req;
  logic [1:0]  grant;
  logic [9:0]  addr;
  logic        we;
  logic        ready;
  logic        tb_drive_en;
  logic [31:0] tb_data;
  wire  [31:0] bus;

  int n_checks = 0;
  int n_fail   = 0;

  assign bus = tb_drive_en ? tb_data : 32'bz;

  shared_memory_arbiter #(
    .n_requesters    (2),
    .memory_size     (1000),
    .memory_size_log (10)
  ) dut (
    .i_Clock          (clk),
    .i_Reset          (rst_n),
    .i_Grant_Request  (req),
    .o_Grant          (grant),
    .i_Memory_Address (addr),
    .i_Write_Enable   (we),
    .io_Memory_Data   (bus),
    .o_Data_Ready     (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; req = 2'b00; addr = '0; we = 1'b0;
    tb_drive_en = 1'b0; tb_data = '0;
    #1;
    check("reset_grant", 32'(grant), 32'h0);
    check("reset_ready", 32'(ready), 32'h0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    check("idle_grant", 32'(grant), 32'h0);

    // Reset priority: host wins first, then turnaround, then control unit
    req = 2'b11;
    tick();
    check("prio_first", 32'(grant), 32'h1);
    req = 2'b10;
    tick();
    check("prio_turnaround", 32'(grant), 32'h0);
    tick();
    check("prio_second", 32'(grant), 32'h2);

    // Hold without preemption
    req = 2'b11;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("hold_no_preempt", 32'(grant), 32'h2);
    end
    req = 2'b01;
    tick();
    check("hold_release", 32'(grant), 32'h0);
    tick();
    check("hold_next_owner", 32'(grant), 32'h1);

    // Host preloads status=0, config word, then status=1
    addr = 10'd1; we = 1'b1; tb_drive_en = 1'b1; tb_data = 32'h0;
    tick();
    addr = 10'd0; tb_data = 32'h04030202;
    tick();
    addr = 10'd1; tb_data = 32'h1;
    tick();
    check("ready_before_update", 32'(ready), 32'h0);
    we = 1'b0; tb_drive_en = 1'b0;
    #1;
    check("host_read_status", bus, 32'h1);
    tick();
    check("ready_set", 32'(ready), 32'h1);
    addr = 10'd0;
    #1;
    check("host_read_config", bus, 32'h04030202);
    req = 2'b00;
    tick();
    check("host_release", 32'(grant), 32'h0);

    // Ungranted: bus must be left alone
    tb_drive_en = 1'b1; tb_data = 32'h0; addr = 10'd0;
    #1;
    check("ungranted_undriven", bus, 32'h0);
    // Ungranted write attempt
    we = 1'b1; tb_data = 32'hDEADBEEF;
    tick();
    we = 1'b0; tb_drive_en = 1'b0;

    // Control unit: config read, status increment
    req = 2'b10;
    tick();
    check("cu_grant", 32'(grant), 32'h2);
    addr = 10'd0;
    #1;
    check("cu_config_read", bus, 32'h04030202);
    addr = 10'd1;
    #1;
    check("cu_status_read", bus, 32'h1);
    we = 1'b1; tb_drive_en = 1'b1; tb_data = 32'h2;
    tick();
    tick();
    // Drop request in the same edge as a write to a different word
    addr = 10'd2; tb_data = 32'h0000A5A5; req = 2'b00;
    tick();
    check("cu_release", 32'(grant), 32'h0);
    check("ready_cleared", 32'(ready), 32'h0);
    we = 1'b0; tb_drive_en = 1'b0;

    // Host checks results and out-of-range behaviour
    req = 2'b01;
    tick();
    check("host_regrant", 32'(grant), 32'h1);
    addr = 10'd1;
    #1;
    check("status_is_2", bus, 32'h2);
    addr = 10'd2;
    #1;
    check("drop_edge_write", bus, 32'h0000A5A5);
    addr = 10'd1023;
    #1;
    check("oor_read", bus, 32'h0);
    we = 1'b1; tb_drive_en = 1'b1; tb_data = 32'h12345678;
    tick();
    addr = 10'd999; tb_data = 32'h0BADF00D;
    tick();
    we = 1'b0; tb_drive_en = 1'b0;
    #1;
    check("last_word_read", bus, 32'h0BADF00D);
    addr = 10'd1023;
    #1;
    check("oor_write_dropped", bus, 32'h0);

    // Reset mid-grant with an in-flight write
    addr = 10'd0; tb_drive_en = 1'b1; tb_data = 32'h0;
    #3;
    rst_n = 1'b0;
    #1;
    check("rst_grant_drop", 32'(grant), 32'h0);
    check("rst_bus_undriven", bus, 32'h0);
    we = 1'b1; tb_data = 32'hFFFFFFFF;
    tick();
    we = 1'b0; tb_drive_en = 1'b0;
    rst_n = 1'b1;
    req = 2'b11;
    tick();
    check("rst_prio", 32'(grant), 32'h1);
    addr = 10'd0;
    #1;
    check("rst_config_intact", bus, 32'h04030202);
    addr = 10'd1;
    #1;
    check("rst_status_intact", bus, 32'h2);
    req = 2'b00;
    tick();
    check("final_release", 32'(grant), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/shared_memory_arbiter.md
# shared_memory_arbiter

Owns the coprocessor's shared 32-bit word memory and arbitrates the tri-state memory bus between the host and the main control unit. It is the responder side of the grant-request / address / data / write-enable protocol: it grants the bus round-robin and serves reads combinationally. It commits writes on the clock edge. It exports `o_Data_Ready` from bit 0 of the status word at address 1, which starts and stops a coprocessor run.

## Interface
- `n_requesters`, 2 — number of bus masters; index 0 = host, index 1 = main control unit.
- `memory_size`, 1024 — number of 32-bit words.
- `memory_size_log`, 10 — address width.
- `i_Clock` in 1 — single clock, rising edge.
- `i_Reset` in 1 — asynchronous, active-low reset.
- `i_Grant_Request` in `n_requesters` — one request line per master.
- `o_Grant` out `n_requesters` — one-hot grant, registered.
- `i_Memory_Address` in `memory_size_log` — shared bus; Z when no master drives it.
- `i_Write_Enable` in 1 — shared tri-state line; the block places a pulldown on it, so only a driven 1 means write.
- `io_Memory_Data` inout 32 — shared data bus.
- `o_Data_Ready` out 1 — registered copy of `mem[1][0]`.

## Operation
- FSM `s_Idle` → `s_Granted` → `s_Idle`; 1-bit state.
- **`s_Idle` with any request:**
  - Pick the first requester after `r_Last_Owner`, in increasing index order with wrap.
  - Set `o_Grant` one-hot, store the owner, go to `s_Granted`.
- **`s_Idle` with no request:** stay, `o_Grant` = 0.
- **`s_Granted`:** while the owner's request stays 1, hold the grant; other requests are ignored (no preemption).
- **Owner request sampled 0:**
  - `o_Grant` goes to 0 at that edge and the FSM returns to `s_Idle`.
  - This gives a mandatory one-cycle bus turnaround before any new grant.
- **Read:**
  - Condition: `o_Grant != 0` and `i_Write_Enable != 1`.
  - `io_Memory_Data` = `mem[i_Memory_Address]` combinationally (asynchronous array read).
  - Otherwise `io_Memory_Data` = Z.
- **Write:** at a rising edge with `o_Grant != 0` and `i_Write_Enable == 1`, `mem[addr] <= io_Memory_Data`.
- **Out-of-range address** (≥ `memory_size`) or address containing X/Z: reads return 0, writes are dropped.
- **Status:** `o_Data_Ready <= mem[1][0]` every cycle.
  - Host writes an odd status to start a run.
  - The control unit's increment makes it even, which stops the run.
- Memory array is not reset. Contents survive `i_Reset`.

## Timing
- **Reset values:**
  - `o_Grant` = 0, `o_Data_Ready` = 0, state = `s_Idle`.
  - `r_Last_Owner` = `n_requesters`−1, so requester 0 wins first.
  - `io_Memory_Data` = Z.
- **Grant latency:** request high before edge k → `o_Grant` high after edge k.
- **Read latency:**
  - Address driven after edge k → data valid on the bus before edge k+1.
  - This matches masters that set the address in one state and sample in the next.
- **Write visibility:**
  - A write at edge k is readable combinationally after edge k.
  - A write to address 1 updates `o_Data_Ready` after edge k+1.
- **Request drop in the same edge as a write** (`i_Write_Enable` still 1): the write commits, then the grant releases.
- **Bus driving:** the block stops driving combinationally when `i_Write_Enable` rises. No contention with the master's write data in the same cycle.
- **Ungranted master driving `i_Write_Enable` = 1:** ignored.
- **Reset mid-grant:** grant drops immediately (asynchronous). An in-flight write at a concurrent edge is not committed.

## Structure
- Package `coproc_mem_pkg`:
  - `CONFIG_ADDR` = 0, `STATUS_ADDR` = 1.
  - State localparams `s_Idle`/`s_Granted`.
  - Data width 32.
- Sub-module `rr_priority_picker`:
  - Combinational.
  - Inputs: request vector and last owner.
  - Outputs: one-hot winner and a valid flag.
- The top level holds the FSM, the array, the tri-state driver and the status register.

## Test plan
- **Reset priority:** after reset, both requests high at the same edge → `o_Grant` = 2'b01 after 1 edge. Host drops → `o_Grant` = 0 for 1 cycle, then 2'b10.
- **Hold, no preemption:** owner 1 holds its request for 10 cycles while requester 0 is high → grant stays 2'b10 the whole time. Owner 1 drops → 2'b01 two edges later.
- **Config read:** preload `mem[0]` = 32'h04_03_02_02. Granted control unit drives address 0 → the bus shows 32'h04030202 before the next edge. Bus is Z when ungranted.
- **Status increment:**
  - Host writes `mem[1]` = 1 → `o_Data_Ready` = 1 one edge later.
  - Control unit reads 1, writes 2 with `i_Write_Enable` = 1 for two cycles, then drops its request → `mem[1]` = 2 and `o_Data_Ready` = 0.
- **Illegal accesses:**
  - Write with `i_Write_Enable` = 1 while ungranted → memory unchanged.
  - Address 1023 with `memory_size` = 1000 → reads 0, write dropped.
- **Reset mid-grant:** assert `i_Reset` low mid-cycle during a grant → `o_Grant` = 0 immediately, bus Z, previously written memory contents intact.
